sparc_ram_ctrl: RTL

- Byte-organised main memory plus access controller consumed by the SPARC MPU's control unit and datapath.
- Takes MAR address, MDR data, and CU access controls (mov, r_w, type).
- Performs big-endian byte/halfword/word transfers at one byte per clock.
- Returns a 4-phase completion handshake (MOC) to the CU state machine.

---
 rtl/sparc_mem_pkg.sv | 24 ++
 rtl/sparc_ram_ctrl_if.sv | 26 ++
 rtl/sparc_ram_array.sv | 20 ++
 rtl/sparc_ram_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC main-memory controller: access-size codes,
// FSM state encoding and the access-size-to-byte-count helper.
package sparc_mem_pkg;

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Code 2'b11 is treated as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] t);
        case (t)
            TYPE_BYTE: size_bytes = 3'd1;
            TYPE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/sparc_ram_ctrl_if.sv
// CU-to-memory access bus: request fields from MAR/MDR/CU, completion and
// read data back to the CU.
interface sparc_ram_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              mov;
    logic              r_w;
    logic [1:0]        type_sel;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;
    logic              MOC;
    logic              busy;
    logic              align_err;

    modport master (
        output mov, r_w, type_sel, Address, DataIn,
        input  DataOut, MOC, busy, align_err
    );

    modport slave (
        input  mov, r_w, type_sel, Address, DataIn,
        output DataOut, MOC, busy, align_err
    );
endinterface

// File: rtl/sparc_ram_array.sv
// Byte-wide main-memory array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module sparc_ram_array #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/sparc_ram_ctrl.sv
// SPARC main-memory access controller: big-endian byte/half/word transfers,
// one byte per clock, 4-phase MOC handshake. Optional SPARC_RAM_ALIGN_CHECK_EN.
module sparc_ram_ctrl
    import sparc_mem_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int DATA_W = 32
) (
    input  logic          Clk,
    input  logic          Clr,
    sparc_ram_ctrl_if.slave bus
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          type_q, type_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                mis_q, mis_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-9:0]   rsh_q, rsh_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                moc_q, moc_d;
    logic                aerr_q, aerr_d;

    logic [2:0]          k;
    logic                last;
    logic [1:0]          idx;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_wdata;
    logic [7:0]          mem_rdata;
    logic [DATA_W-1:0]   shifted;
    logic                req_mis;

    assign k         = size_bytes(type_q);
    assign last      = (({1'b0, cnt_q} + 3'd1) == k);
    // Byte cnt of a k-byte field is bit-slice k-1-cnt: MSB first.
    assign idx       = 2'(k - 3'd1 - {1'b0, cnt_q});
    assign mem_addr  = addr_q + ADDR_W'(cnt_q);
    assign mem_wdata = wdata_q[{idx, 3'b000} +: 8];
    assign shifted   = {rsh_q, mem_rdata};

`ifdef SPARC_RAM_ALIGN_CHECK_EN
    assign req_mis = (bus.type_sel == TYPE_HALF) ? bus.Address[0] :
                     (bus.type_sel == TYPE_BYTE) ? 1'b0 : (|bus.Address[1:0]);
`else
    assign req_mis = 1'b0;
`endif

    sparc_ram_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (Clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            type_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
            rsh_q   <= '0;
            dout_q  <= '0;
            moc_q   <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
            rsh_q   <= rsh_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            aerr_q  <= aerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        rsh_d   = rsh_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        aerr_d  = aerr_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mov) begin
                    addr_d  = bus.Address;
                    type_d  = bus.type_sel;
                    rw_d    = bus.r_w;
                    wdata_d = bus.DataIn;
                    mis_d   = req_mis;
                    cnt_d   = '0;
                    rsh_d   = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (mis_q) begin
                    // Rejected access: no array traffic, DataOut untouched.
                    moc_d   = 1'b1;
                    aerr_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    mem_we = !rw_q;
                    rsh_d  = shifted[DATA_W-9:0];
                    cnt_d  = cnt_q + 2'd1;
                    if (last) begin
                        if (rw_q) dout_d = shifted;
                        moc_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!bus.mov) begin
                    moc_d   = 1'b0;
                    aerr_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.DataOut   = dout_q;
    assign bus.MOC       = moc_q;
    assign bus.busy      = (state_q == ST_XFER);
    assign bus.align_err = aerr_q;
endmodule
